state_unpacker: RTL and testbench
=================================

Name: state_unpacker

Overview:
- Reverse direction of the packing path. Accepts one 128-bit AES state from the state register/bank.
- Slices the state into 32-bit words: AES rows (normal mode) or AES columns (MixColumns mode).
- Streams the words to the ALU lanes in beats of LANES words, using a valid/ready handshake on each side.
- Sits between the state register file and the vector ALU operand inputs.

Parameters:
- LANES, 2, number of 32-bit ALU lanes fed per beat; legal values 1, 2, 4; BEATS = 4/LANES.
- BEAT_W, 2, width of the beat index output; must hold BEATS-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous abort; drops any held state.
- in_valid  in  1  state_in/mc_mode valid.
- in_ready  out  1  unpacker can accept a new state this cycle.
- state_in  in  128  AES state; byte i at bits [127-8i -: 8], column-major (byte i = row i%4, column i/4).
- mc_mode  in  1  1 = column slicing (MixColumns), 0 = row slicing.
- out_valid  out  1  op_out holds a valid beat.
- out_ready  in  1  ALU consumes the beat.
- op_out  out  LANES*32  lane k at bits [32k+31:32k]; lane 0 carries the lowest word index of the beat.
- beat_idx  out  BEAT_W  index of the current beat, 0..BEATS-1.
- last  out  1  high with out_valid on beat BEATS-1.
- mode_out  out  1  latched mc_mode of the state being streamed.

Behaviour:
- Reset (async, rst=1) values: FSM=IDLE, out_valid=0, in_ready=1, op_out=0, beat_idx=0, last=0, mode_out=0, holding register=0.
- Word slicing:
  - Column mode: word j = bytes 4j, 4j+1, 4j+2, 4j+3, MSB-first.
  - Row mode: word j = bytes j, j+4, j+8, j+12, MSB-first.
  - Beat b carries words b*LANES .. b*LANES+LANES-1.
- FSM states:
  - IDLE:
    - in_ready=1, out_valid=0.
    - On in_valid: latch state_in and mc_mode, beat_cnt=0, go to SEND.
    - Latency from load to out_valid is 1 cycle.
  - SEND:
    - out_valid=1; op_out, beat_idx, last and mode_out are sliced from the holding register and beat_cnt.
    - All outputs hold stable while out_ready=0.
    - On out_ready and not last: beat_cnt+1.
    - On out_ready and last with in_valid=1: reload, beat_cnt=0, stay in SEND. There is no bubble, so a continuous stream sustains one beat per cycle.
    - On out_ready and last with in_valid=0: go to IDLE.
- in_ready in SEND = last & out_ready (combinational from out_ready). in_valid is ignored when in_ready=0.
- mc_mode is sampled only at load. Changing it mid-stream has no effect until the next load.
- beat_cnt wraps only through a reload or a return to IDLE. It never passes BEATS-1.
- LANES=4: a single beat; last=1 on every beat.
- flush=1: next cycle FSM=IDLE, out_valid=0, beat_cnt=0. Flush has priority over a simultaneous load or handshake.
- rst asserted mid-stream: outputs return to reset values immediately. The partial state is lost and no beat is replayed.
- op_out is registered, not a combinational path from state_in. Its only combinational dependency is on the held register and beat_cnt.

Decomposition:
- Shared package aes_pkg:
  - typedef aes_state_t (logic [127:0]).
  - typedef aes_word_t (logic [31:0]).
  - enum unpack_state_e {IDLE, SEND}.
  - constants STATE_WORDS=4, BYTE_W=8.
  - function get_byte(state, idx).
- One sub-module, state_word_slicer: combinational; inputs are state, mode and word index; output is one 32-bit word. Instantiated LANES times.

Test Plan:
- Column mode, LANES=2, out_ready=1, state_in=0x0102030405060708090a0b0c0d0e0f10, mc_mode=1:
  - beat0: op_out lane0=0x01020304, lane1=0x05060708.
  - beat1: lane0=0x090a0b0c, lane1=0x0d0e0f10, last=1.
  - FSM returns to IDLE.
- Row mode, same state, mc_mode=0:
  - beat0: lane0=0x0105090d, lane1=0x02060a0e.
  - beat1: lane0=0x03070b0f, lane1=0x04080c10.
  - mode_out=0 throughout.
- Backpressure: out_ready=0 for 3 cycles on beat0 → op_out and beat_idx stay constant, in_ready=0, and a new in_valid is ignored.
- Back-to-back: two states offered with in_valid held, out_ready=1 → 4 consecutive valid beats with no idle cycle; the second state's beat0 follows the first state's last beat directly.
- flush at beat1 (out_ready=0) → next cycle out_valid=0, in_ready=1; the next load starts at beat_idx=0.
- Async rst pulse mid-beat0 → out_valid drops in the same cycle without waiting for clk; after release, in_ready=1 and op_out=0.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES state types, unpacker FSM states and byte-extraction helper
package aes_pkg;
  typedef logic [127:0] aes_state_t;
  typedef logic [31:0] aes_word_t;
  typedef enum logic {IDLE, SEND} unpack_state_e;
  localparam int STATE_WORDS = 4;
  localparam int BYTE_W = 8;
  function automatic logic [BYTE_W-1:0] get_byte(aes_state_t state, logic [3:0] idx);
    return state[BYTE_W*(15-int'(idx)) +: BYTE_W];
  endfunction
endpackage

// File: rtl/state_word_slicer.sv
// state_word_slicer: picks one 32-bit AES row (mode=0) or column (mode=1) word from a state
module state_word_slicer
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic         mode,
  input  logic [1:0]   idx,
  output logic [31:0]  word
);
  always_comb begin
    word = '0;
    for (int r = 0; r < 4; r++)
      word[31-BYTE_W*r -: BYTE_W] = get_byte(state, mode ? {idx, 2'(r)} : {2'(r), idx});
  end
endmodule

// File: rtl/state_unpacker.sv
// state_unpacker: holds one AES state and streams its row/column words to the ALU lanes
module state_unpacker
  import aes_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int BEAT_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        state_in,
  input  logic                mc_mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LANES*32-1:0] op_out,
  output logic [BEAT_W-1:0]   beat_idx,
  output logic                last,
  output logic                mode_out
);
  localparam int BEATS = STATE_WORDS / LANES;
  unpack_state_e st;
  aes_state_t hold;
  logic mode;
  logic [BEAT_W-1:0] cnt;
  logic load;
  assign out_valid = st == SEND;
  assign last      = out_valid && cnt == BEAT_W'(BEATS-1);
  assign in_ready  = st == IDLE || (last && out_ready);
  assign load      = in_valid && in_ready && !flush;
  assign beat_idx  = cnt;
  assign mode_out  = mode;
  always_ff @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      st   <= IDLE;
      hold <= '0;
      mode <= 1'b0;
      cnt  <= '0;
    end else if (load) begin
      st   <= SEND;
      hold <= state_in;
      mode <= mc_mode;
      cnt  <= '0;
    end else if (out_valid && out_ready) begin
      st  <= last ? IDLE : SEND;
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end
  // op_out is a pure function of registered state, never of state_in
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    state_word_slicer u_slicer (
      .state (hold),
      .mode  (mode),
      .idx   (2'(int'(cnt)*LANES + k)),
      .word  (op_out[32*k +: 32])
    );
  end
endmodule

// File: tb/tb_state_unpacker.sv
// tb_state_unpacker: directed checks of slicing, handshake, flush and async reset
module tb_state_unpacker;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0, mc_mode = 0;
  logic [127:0] state_in = '0;
  logic in_ready, out_valid, last, mode_out;
  logic [63:0] op_out;
  logic [1:0] beat_idx;
  int checks = 0, passed = 0;
  localparam logic [127:0] S = 128'h0102030405060708090a0b0c0d0e0f10;
  localparam logic [127:0] S2 = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [63:0] C0 = 64'h05060708_01020304, C1 = 64'h0d0e0f10_090a0b0c;
  localparam logic [63:0] R0 = 64'h02060a0e_0105090d, R1 = 64'h04080c10_03070b0f;

  state_unpacker #(.LANES(2), .BEAT_W(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .state_in(state_in), .mc_mode(mc_mode), .out_valid(out_valid), .out_ready(out_ready),
    .op_out(op_out), .beat_idx(beat_idx), .last(last), .mode_out(mode_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic beat(input string tag, input logic [63:0] op, input logic [1:0] b,
                      input logic l, input logic m);
    chk({tag, " valid"}, 64'(out_valid), 64'd1);
    chk({tag, " op"}, op_out, op);
    chk({tag, " idx"}, 64'(beat_idx), 64'(b));
    chk({tag, " last"}, 64'(last), 64'(l));
    chk({tag, " mode"}, 64'(mode_out), 64'(m));
  endtask

  initial begin
    #2;
    chk("rst valid", 64'(out_valid), 64'd0);
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst op", op_out, 64'd0);
    chk("rst idx", 64'(beat_idx), 64'd0);
    chk("rst last", 64'(last), 64'd0);
    chk("rst mode", 64'(mode_out), 64'd0);
    @(negedge clk) rst = 0;
    // column mode
    @(negedge clk) begin in_valid = 1; state_in = S; mc_mode = 1; out_ready = 1; end
    @(negedge clk) in_valid = 0;
    beat("col b0", C0, 2'd0, 1'b0, 1'b1);
    @(negedge clk) beat("col b1", C1, 2'd1, 1'b1, 1'b1);
    chk("col last in_ready", 64'(in_ready), 64'd1);
    @(negedge clk) chk("col idle", 64'(out_valid), 64'd0);
    // row mode
    @(negedge clk) begin in_valid = 1; mc_mode = 0; end
    @(negedge clk) in_valid = 0;
    beat("row b0", R0, 2'd0, 1'b0, 1'b0);
    @(negedge clk) beat("row b1", R1, 2'd1, 1'b1, 1'b0);
    @(negedge clk) chk("row idle", 64'(out_valid), 64'd0);
    // backpressure with an ignored offer
    @(negedge clk) begin in_valid = 1; mc_mode = 1; out_ready = 0; end
    @(negedge clk) begin state_in = S2; mc_mode = 0; end
    for (int i = 0; i < 3; i++) begin
      beat("stall", C0, 2'd0, 1'b0, 1'b1);
      chk("stall in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    in_valid = 0; out_ready = 1;
    @(negedge clk) beat("stall b1", C1, 2'd1, 1'b1, 1'b1);
    @(negedge clk) chk("stall idle", 64'(out_valid), 64'd0);
    // back-to-back
    @(negedge clk) begin in_valid = 1; state_in = S; mc_mode = 1; end
    @(negedge clk) mc_mode = 0;
    beat("b2b c0", C0, 2'd0, 1'b0, 1'b1);
    @(negedge clk) beat("b2b c1", C1, 2'd1, 1'b1, 1'b1);
    @(negedge clk) in_valid = 0;
    beat("b2b r0", R0, 2'd0, 1'b0, 1'b0);
    @(negedge clk) beat("b2b r1", R1, 2'd1, 1'b1, 1'b0);
    @(negedge clk) chk("b2b idle", 64'(out_valid), 64'd0);
    // flush on beat1
    @(negedge clk) begin in_valid = 1; mc_mode = 1; end
    @(negedge clk) in_valid = 0;
    @(negedge clk) begin out_ready = 0; flush = 1; end
    chk("flush pre idx", 64'(beat_idx), 64'd1);
    @(negedge clk) flush = 0;
    chk("flush valid", 64'(out_valid), 64'd0);
    chk("flush in_ready", 64'(in_ready), 64'd1);
    in_valid = 1; mc_mode = 0; out_ready = 1;
    @(negedge clk) in_valid = 0;
    beat("post flush", R0, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk) begin in_valid = 1; mc_mode = 1; out_ready = 0; end
    @(negedge clk) in_valid = 0;
    chk("pre rst valid", 64'(out_valid), 64'd1);
    // async reset between clock edges
    #2 rst = 1;
    #1 chk("async rst valid", 64'(out_valid), 64'd0);
    #1 rst = 0;
    @(negedge clk);
    chk("post rst in_ready", 64'(in_ready), 64'd1);
    chk("post rst op", op_out, 64'd0);
    chk("post rst valid", 64'(out_valid), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
